dmem_store_buffer: RTL

Store buffer between the MEM pipeline stage and the data memory (`dmem`). Stores from the pipeline are enqueued into a small FIFO, already converted to `dmem`'s byte-lane mask (`amp`) encoding. The buffer then drains them one per cycle onto `dmem`'s single address/write port whenever a load is not using that port. A load that hits the word of any pending store is stalled until that store retires, so loads never read stale data.

---
 rtl/dmem_store_buffer.sv | 104 ++++++++++
 1 files changed

// File: rtl/dmem_store_buffer.sv
// Store buffer between the MEM stage and dmem: stores are queued with their
// byte-lane mask and drained in order whenever a load is not using the port.
module dmem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [2:0]               st_funct3,
  input  logic [XLEN-1:0]          st_addr,
  input  logic [XLEN-1:0]          st_data,
  input  logic [XLEN-1:0]          st_pc,
  input  logic                     ld_valid,
  input  logic [XLEN-1:0]          ld_addr,
  output logic                     ld_stall,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     mem_we,
  output logic [XLEN-1:0]          mem_a,
  output logic [XLEN-1:0]          mem_wd,
  output logic [3:0]               mem_amp,
  output logic [XLEN-1:0]          mem_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] addr_q [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [XLEN-1:0] pc_q   [DEPTH];
  logic [3:0]      amp_q  [DEPTH];

  logic [PW-1:0]   head, tail;
  logic [CW-1:0]   cnt;
  logic [3:0]      st_amp;
  logic [DEPTH-1:0] hit_vec;
  logic [PW-1:0]   off;
  logic            hit, ld_grant, enq, deq;

  always_comb begin
    st_amp = 4'b1111;
    case (st_funct3)
      3'b000:  st_amp = 4'b0001 << st_addr[1:0];
      3'b001:  st_amp = st_addr[1] ? 4'b1100 : 4'b0011;
      default: st_amp = 4'b1111;
    endcase
  end

  // An entry is live when its distance from head is below count.
  always_comb begin
    hit_vec = '0;
    off     = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off = PW'(i) - head;
      if ((CW'(off) < cnt) && (addr_q[i][11:2] == ld_addr[11:2]))
        hit_vec[i] = 1'b1;
    end
  end

  assign hit      = ld_valid && (|hit_vec);
  assign ld_grant = ld_valid && !hit;
  assign empty    = (cnt == '0);
  assign st_ready = (cnt != CW'(DEPTH));
  assign count    = cnt;
  assign ld_stall = hit;
  assign enq      = st_valid && st_ready;
  assign deq      = !ld_grant && !empty;

  always_comb begin
    mem_we  = deq;
    mem_a   = ld_grant ? ld_addr : addr_q[head];
    mem_wd  = data_q[head];
    mem_amp = amp_q[head];
    mem_pc  = pc_q[head];
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail] <= st_addr;
      data_q[tail] <= st_data;
      pc_q[tail]   <= st_pc;
      amp_q[tail]  <= st_amp;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (enq) tail <= tail + 1'b1;
      if (deq) head <= head + 1'b1;
      case ({enq, deq})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule
